// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 packet demultiplexer.
// Holds the channel count, address width, FSM encoding and a one-hot decode helper.
package demux_pkg;

  localparam int NUM_CHAN = 4;
  localparam int ADDR_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  function automatic logic [NUM_CHAN-1:0] chan_onehot(input logic [ADDR_W-1:0] ch);
    logic [NUM_CHAN-1:0] oh;
    oh     = {NUM_CHAN{1'b0}};
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/packet_demultiplexer_if.sv
// Beat-stream bundle for the demultiplexer: one valid/ready input stream and
// four one-hot qualified output channels sharing a data/last bus.
interface packet_demultiplexer_if #(
  parameter int DATA_W = 8
);
  import demux_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_last;
  logic                address0;
  logic                address1;
  logic [NUM_CHAN-1:0] chan_enable;
  logic [NUM_CHAN-1:0] out_valid;
  logic [NUM_CHAN-1:0] out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;

  modport master (
    output in_valid, in_data, in_last, address0, address1, chan_enable, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, address0, address1, chan_enable, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/demux_out_stage.sv
// Single-entry output register carrying one beat and its destination channel.
// A load takes priority over a drain so that drain-and-reload sustains one beat per cycle.
module demux_out_stage
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] load_chan,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [ADDR_W-1:0] chan
);

  logic              full_r;
  logic [DATA_W-1:0] data_r;
  logic              last_r;
  logic [ADDR_W-1:0] chan_r;

  // Beat register: payload only changes on load, so it holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 1'b0;
      data_r <= {DATA_W{1'b0}};
      last_r <= 1'b0;
      chan_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      full_r <= 1'b1;
      data_r <= load_data;
      last_r <= load_last;
      chan_r <= load_chan;
    end else if (drain) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign full = full_r;
  assign data = data_r;
  assign last = last_r;
  assign chan = chan_r;

endmodule

// File: rtl/packet_demultiplexer.sv
// 1-to-4 packet demultiplexer: steers each packet to the channel addressed on its
// first beat, drops packets aimed at disabled channels and counts them (saturating).
module packet_demultiplexer
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  packet_demultiplexer_if.slave  bus,
  output logic [CNT_W-1:0]       drop_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   dest_r;
  logic [ADDR_W-1:0]   dest_s;
  logic [CNT_W-1:0]    drop_count_r;

  logic [ADDR_W-1:0]   addr_in_s;
  logic                full_s;
  logic [ADDR_W-1:0]   held_chan_s;
  logic [DATA_W-1:0]   held_data_s;
  logic                held_last_s;
  logic                drained_s;
  logic                fwd_ready_s;
  logic                ready_s;
  logic                accept_s;
  logic                load_s;
  logic [ADDR_W-1:0]   load_chan_s;
  logic                drop_inc_s;

  assign addr_in_s   = {bus.address1, bus.address0};
  // Only the held channel's ready can free the register.
  assign drained_s   = full_s & bus.out_ready[held_chan_s];
  assign fwd_ready_s = ~full_s | drained_s;
  assign accept_s    = bus.in_valid & ready_s;

  // Input ready: beats headed for the discard path never wait on the output register.
  always_comb begin
    ready_s = 1'b0;
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    ready_s = bus.chan_enable[addr_in_s] ? fwd_ready_s : 1'b1;
        ROUTE:   ready_s = fwd_ready_s;
        DROP:    ready_s = 1'b1;
        default: ready_s = 1'b0;
      endcase
    end
  end

  // Next-state, destination latch and output-stage load decisions.
  always_comb begin
    state_s     = state_r;
    dest_s      = dest_r;
    load_s      = 1'b0;
    load_chan_s = dest_r;
    drop_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          dest_s = addr_in_s;
          if (bus.chan_enable[addr_in_s]) begin
            load_s      = 1'b1;
            load_chan_s = addr_in_s;
            state_s     = bus.in_last ? IDLE : ROUTE;
          end else begin
            drop_inc_s = bus.in_last;
            state_s    = bus.in_last ? IDLE : DROP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ROUTE: begin
        if (accept_s) begin
          load_s      = 1'b1;
          load_chan_s = dest_r;
          state_s     = bus.in_last ? IDLE : ROUTE;
        end else begin
          state_s = ROUTE;
        end
      end
      DROP: begin
        if (accept_s && bus.in_last) begin
          drop_inc_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and latched destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      dest_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      dest_r  <= dest_s;
    end
  end

  // Saturating count of packets discarded on disabled channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= {CNT_W{1'b0}};
    end else if (drop_inc_s && (drop_count_r != CNT_MAX)) begin
      drop_count_r <= drop_count_r + CNT_ONE;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  demux_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .drain     (drained_s),
    .load_data (bus.in_data),
    .load_last (bus.in_last),
    .load_chan (load_chan_s),
    .full      (full_s),
    .data      (held_data_s),
    .last      (held_last_s),
    .chan      (held_chan_s)
  );

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = full_s ? chan_onehot(held_chan_s) : {NUM_CHAN{1'b0}};
  assign bus.out_data  = held_data_s;
  assign bus.out_last  = held_last_s;
  assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_packet_demultiplexer.sv
// Bench for packet_demultiplexer: directed scenarios plus random traffic, every cycle
// compared against a packet-level reference model of the routing/drop rules.
module tb_packet_demultiplexer;
  import demux_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [3:0] ALL = 4'hF;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] drop_count;

  packet_demultiplexer_if #(.DATA_W(DATA_W)) bus ();

  packet_demultiplexer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: output register contents plus packet-level progress.
  bit         m_held;
  int         m_chan;
  logic [7:0] m_data;
  bit         m_last;
  bit         m_in_pkt;
  bit         m_drop;
  int         m_dest;
  int         m_drops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_chan = 0; m_data = 8'h00; m_last = 0;
    m_in_pkt = 0; m_drop = 0; m_dest = 0; m_drops = 0;
  endtask

  // One clock: drive inputs after a falling edge, check, advance model, wait next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input logic [1:0] a,
                      input logic [3:0] en, input logic [3:0] ordy, input bit rst);
    bit         exp_ready;
    logic [3:0] exp_ov;
    bit         drained;
    bit         acc;
    int         nd;
    bit         ndrop;
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_last     = l;
    bus.address0    = a[0];
    bus.address1    = a[1];
    bus.chan_enable = en;
    bus.out_ready   = ordy;
    reset           = rst;
    #1;
    if (rst)                       exp_ready = 0;
    else if (m_in_pkt && m_drop)   exp_ready = 1;
    else if (!m_in_pkt && !en[a])  exp_ready = 1;
    else                           exp_ready = !m_held || ordy[m_chan];
    exp_ov = m_held ? (4'b0001 << m_chan) : 4'b0000;
    check("in_ready",   bus.in_ready,  exp_ready);
    check("out_valid",  bus.out_valid, exp_ov);
    check("out_data",   bus.out_data,  m_data);
    check("out_last",   bus.out_last,  m_last);
    check("drop_count", drop_count,    m_drops);
    if (rst) begin
      model_reset();
    end else begin
      drained = m_held && ordy[m_chan];
      acc     = v && exp_ready;
      nd      = m_in_pkt ? m_dest : int'(a);
      ndrop   = m_in_pkt ? m_drop : !en[a];
      if (acc && !ndrop) begin
        m_held = 1; m_chan = nd; m_data = d; m_last = l;
      end else if (drained) begin
        m_held = 0;
      end
      if (acc) begin
        if (ndrop && l && m_drops < CNT_MAX) m_drops++;
        m_in_pkt = !l;
        m_dest   = nd;
        m_drop   = ndrop;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 2'd0, ALL, ALL, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    bus.address0 = 1'b0; bus.address1 = 1'b0;
    bus.chan_enable = ALL; bus.out_ready = ALL;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    step(1'b0, 8'h00, 1'b0, 2'd0, ALL, ALL, 1'b1);

    // Reset in the middle of a 4-beat packet to ch1.
    step(1'b1, 8'h11, 1'b0, 2'd1, ALL, ALL, 1'b0);
    step(1'b1, 8'h12, 1'b0, 2'd1, ALL, ALL, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd1, ALL, ALL, 1'b1);
    check("t1_ov_after_reset", bus.out_valid, 4'b0000);
    check("t1_drop_after_reset", drop_count, 8'd0);
    step(1'b1, 8'h13, 1'b1, 2'd2, ALL, ALL, 1'b0);
    check("t1_new_addr", bus.out_valid, 4'b0100);

    // Single-beat packets to every channel back to back.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b1, 2'(i), ALL, ALL, 1'b0);
      check("t2_ov", bus.out_valid, 4'b0001 << i);
    end
    idle();

    // Address changes mid-packet must be ignored.
    step(1'b1, 8'h30, 1'b0, 2'd2, ALL, ALL, 1'b0);
    step(1'b1, 8'h31, 1'b0, 2'd3, ALL, ALL, 1'b0);
    check("t3_beat2_ov", bus.out_valid, 4'b0100);
    step(1'b1, 8'h32, 1'b1, 2'd3, 4'b0011, ALL, 1'b0);
    check("t3_beat3_ov", bus.out_valid, 4'b0100);
    check("t3_last", bus.out_last, 1'b1);
    idle();

    // Backpressure on ch1; ready on ch0 must not release it.
    step(1'b1, 8'h40, 1'b1, 2'd1, ALL, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h41, 1'b1, 2'd1, ALL, 4'b0001, 1'b0);
      check("t4_ready_low", bus.in_ready, 1'b0);
      check("t4_data_hold", bus.out_data, 8'h40);
    end
    step(1'b1, 8'h41, 1'b1, 2'd1, ALL, 4'b0010, 1'b0);
    check("t4_reload_data", bus.out_data, 8'h41);
    check("t4_reload_ov", bus.out_valid, 4'b0010);
    idle();

    // Disabled ch2: packets dropped and counted up to saturation.
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 8'h50, 1'b0, 2'd2, 4'b1011, ALL, 1'b0);
      step(1'b1, 8'h51, 1'b1, 2'd2, 4'b1011, ALL, 1'b0);
      if (k == 0) begin
        check("t5_first_drop", drop_count, 8'd1);
        check("t5_no_valid", bus.out_valid, 4'b0000);
      end
    end
    check("t5_saturated", drop_count, 8'd255);
    idle();

    // Eight single-beat packets stream with no bubbles.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 2'($urandom_range(0, 3)), ALL, ALL, 1'b0);
      check("t6_no_bubble", |bus.out_valid, 1'b1);
    end

    // Random traffic with occasional resets, disabled channels and backpressure.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] en;
      logic [3:0] ordy;
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ALL;
      for (int b = 0; b < 4; b++) ordy[b] = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), en, ordy, ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
